// File: rtl/fetch_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// fetch_queue : fetch PC, in-order imem request issue and decode-side queue.
// Optional macro FETCH_PERF_EN adds fetched/dropped counters.  Rev 1.0
//------------------------------------------------------------------------------
module fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic [31:0]   target;
  logic [SW-1:0] inflight;
  logic          handshake;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic          unused_tgt_lsbs;

  assign target          = {PCTargetE[31:2], 2'b00};
  assign unused_tgt_lsbs = ^PCTargetE[1:0];

  // Credit rule: queued words plus words still in flight never exceed DEPTH,
  // so a returning response always has a free slot.
  assign inflight  = SW'(count_q) + SW'(outst_q);
  assign req_valid = rst_n && !PCSrcE
                     && (outst_q < OW'(MAX_OUTSTANDING))
                     && (inflight < SW'(DEPTH));
  assign req_addr  = fetch_pc_q;
  assign handshake = req_valid && req_ready;

  assign rsp_drop  = rsp_valid && (drop_q != '0);
  assign push      = rsp_valid && (drop_q == '0) && !PCSrcE;
  assign pop       = ValidD && !StallD && !PCSrcE;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    outst_d    = outst_q + OW'(handshake) - OW'(rsp_valid);

    if (PCSrcE) begin
      // Every request still unreturned after this edge belongs to the old path.
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_d     = outst_q - OW'(rsp_valid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (handshake) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        drop_d = drop_q - OW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= RESET_PC;
      end
    end else if (push) begin
      instr_mem_q[wr_ptr_q] <= rsp_data;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // Decode outputs come only from registers, never from rsp_* directly.
  assign ValidD   = (count_q != '0);
  assign InstrD   = instr_mem_q[rd_ptr_q];
  assign PCD      = pc_mem_q[rd_ptr_q];
  assign PCPlus4D = PCD + 32'd4;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_dropped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      if (push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (rsp_drop) begin
        perf_dropped_q <= perf_dropped_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_fetch_queue : randomized bench with a queue-based fetch/imem reference.
// Rev 1.0
//------------------------------------------------------------------------------
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        StallD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_queue #(
    .RESET_PC        (RESET_PC),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic stale; } req_t;
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;

  // Reference: requests in flight at the imem, and words waiting for decode.
  req_t        pend[$];
  ent_t        fq[$];
  logic [31:0] m_fetch_pc;
  int          m_fetched, m_dropped;
  int          cyc, first_valid;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ready_pct, rsp_pct, stall_pct, redir_pct;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  logic [31:0] key = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    pend.delete();
    fq.delete();
    m_fetch_pc  = RESET_PC;
    m_fetched   = 0;
    m_dropped   = 0;
    cyc         = 0;
    first_valid = -1;
  endtask

  // Called at a falling edge; asserts reset mid-cycle, releases on a falling edge.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    StallD    = 1'b0;
    PCSrcE    = 1'b0;
    #1;
    check("rst_valid_d", ValidD, 1'b0);
    check("rst_req_valid", req_valid, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_instr_d", InstrD, 32'h0);
    check("rst_pc_d", PCD, RESET_PC);
    check("rst_pcplus4_d", PCPlus4D, RESET_PC + 32'd4);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, check 1 ns later, advance the model.
  task automatic cycle();
    bit          rdy, stall, redir, rv, exp_rv, exp_vd, pop;
    logic [31:0] tgt;
    req_t        r;
    rdy   = ($urandom_range(99) < ready_pct);
    stall = ($urandom_range(99) < stall_pct);
    redir = force_redir || ($urandom_range(99) < redir_pct);
    tgt   = force_redir ? force_tgt : $urandom;
    force_redir = 1'b0;
    rv    = (pend.size() > 0) && ($urandom_range(99) < rsp_pct);

    req_ready = rdy;
    StallD    = stall;
    PCSrcE    = redir;
    PCTargetE = tgt;
    rsp_valid = rv;
    rsp_data  = rv ? (pend[0].addr ^ key) : $urandom;
    #1;

    exp_rv = !redir && (pend.size() < MAX_OUT) && ((fq.size() + pend.size()) < DEPTH);
    exp_vd = (fq.size() > 0);
    check("req_valid", req_valid, exp_rv);
    if (exp_rv) check("req_addr", req_addr, m_fetch_pc);
    check("ValidD", ValidD, exp_vd);
    if (exp_vd) begin
      check("InstrD", InstrD, fq[0].instr);
      check("PCD", PCD, fq[0].pc);
      check("PCPlus4D", PCPlus4D, fq[0].pc + 32'd4);
      if (first_valid < 0) first_valid = cyc;
    end

    pop = exp_vd && !stall && !redir;
    if (rv) begin
      r = pend.pop_front();
      if (r.stale) m_dropped++;
      else if (!redir) begin
        fq.push_back('{rsp_data, r.addr});
        m_fetched++;
      end
    end
    if (pop) void'(fq.pop_front());
    if (redir) begin
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      fq.delete();
      m_fetch_pc = {tgt[31:2], 2'b00};
    end else if (exp_rv && rdy) begin
      pend.push_back('{m_fetch_pc, 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_mode(input int rdy, input int rsp, input int stl, input int rdr);
    ready_pct = rdy;
    rsp_pct   = rsp;
    stall_pct = stl;
    redir_pct = rdr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Zero-wait imem, data equals address.
    set_mode(100, 100, 0, 0);
    repeat (10) cycle();
    check("first_valid_cycle", first_valid, 32'd2);

    // Decode stall fills the queue, then drains in order.
    set_mode(100, 100, 100, 0);
    repeat (6) cycle();
    check("stall_full_req_valid", req_valid, 1'b0);
    set_mode(100, 100, 0, 0);
    repeat (6) cycle();

    // Build two outstanding requests, then redirect to a misaligned target.
    set_mode(100, 0, 0, 0);
    repeat (2) cycle();
    force_redir = 1'b1;
    force_tgt   = 32'h0000_0103;
    cycle();
    check("redir_next_valid_d", ValidD, 1'b0);
    set_mode(100, 100, 0, 0);
    for (int i = 0; i < 12 && !ValidD; i++) cycle();
    check("redir_valid_seen", ValidD, 1'b1);
    check("redir_first_pcd", PCD, 32'h0000_0100);

    // imem not ready for five cycles: decode drains, then resumes.
    set_mode(0, 100, 0, 0);
    repeat (5) cycle();
    check("not_ready_drained", ValidD, 1'b0);
    set_mode(100, 100, 0, 0);
    repeat (6) cycle();

    // Address wrap at the top of the address space.
    force_redir = 1'b1;
    force_tgt   = 32'hFFFF_FFF8;
    cycle();
    for (int i = 0; i < 12 && !(ValidD && PCD == 32'hFFFF_FFFC); i++) cycle();
    check("wrap_pcd", PCD, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4D, 32'h0000_0000);
    repeat (4) cycle();

    // Randomized traffic with scrambled data.
    key = $urandom;
    set_mode(70, 60, 30, 5);
    repeat (3000) cycle();
    set_mode(90, 90, 60, 12);
    repeat (1500) cycle();

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_dropped", perf_dropped, m_dropped);
`endif

    // Reset in the middle of traffic with a full queue.
    set_mode(100, 100, 100, 0);
    repeat (8) cycle();
    do_reset();
    set_mode(100, 100, 0, 0);
    repeat (8) cycle();
    check("post_reset_first_valid", first_valid, 32'd2);

    set_mode(60, 50, 40, 8);
    repeat (1500) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
